instruction_loader: RTL and testbench

//  Writer side of the 16-bit instruction memory: receives a program image as a byte stream
//  (from the UART receiver) and writes it word by word into instruction memory from START_ADDR.

---
 rtl/instruction_loader_pkg.sv | 23 ++
 rtl/instruction_loader.sv | 148 ++++++++++++++
 tb/tb_instruction_loader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction image loader.
// Holds the FSM state encoding, the default sync byte and word/address widths.
// Imported by the loader top; no logic lives here.
package instruction_loader_pkg;

    localparam int          WORD_W        = 16;
    localparam int          ADDR_W        = 16;
    localparam int          DEPTH_DEF     = 256;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

    // Loader FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CSUM    = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

endpackage

// File: rtl/instruction_loader.sv
// Parses a SYNC/LEN/WORDS/CSUM byte stream and writes 16-bit words into instruction memory.
// Latency: memory write strobe is registered, one cycle after the WORD_LO byte transfer.
// Backpressure: rx_ready is low only for the single DONE cycle; every other cycle accepts a byte.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int                 DEPTH      = DEPTH_DEF,
    parameter logic [ADDR_W-1:0]  START_ADDR = 16'h0,
    parameter logic [7:0]         SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_rx_ready,
    output logic               o_imem_we,
    output logic [ADDR_W-1:0]  o_imem_addr,
    output logic [WORD_W-1:0]  o_imem_wdata,
    output logic               o_cpu_hold,
    output logic               o_load_done,
    output logic               o_load_error
);

    // Length limit widened by one bit so a 16-bit length never overflows the compare
    localparam logic [16:0] LP_DEPTH = 17'(DEPTH);

    state_t              r_state;
    state_t              w_state_next;
    logic [15:0]         r_len;
    logic [15:0]         r_count;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_hi;
    logic [7:0]          r_csum;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [WORD_W-1:0]   r_imem_wdata;

    logic                w_rx_ready;
    logic                w_xfer;
    logic                w_is_sync;
    logic                w_sync_start;
    logic [15:0]         w_len_full;
    logic [15:0]         w_count_inc;

    assign w_xfer       = i_rx_valid & w_rx_ready;
    assign w_is_sync    = (i_rx_data == SYNC_BYTE);
    // SYNC only restarts from IDLE or ERROR; inside a frame it is ordinary data
    assign w_sync_start = w_xfer & w_is_sync & ((r_state == ST_IDLE) | (r_state == ST_ERROR));
    assign w_len_full   = {r_len[15:8], i_rx_data};
    assign w_count_inc  = r_count + 16'd1;

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: every transition except DONE->IDLE waits for a byte transfer
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_sync_start) w_state_next = ST_LEN_HI;
            ST_LEN_HI:  if (w_xfer) w_state_next = ST_LEN_LO;
            ST_LEN_LO: begin
                if (w_xfer) begin
                    if (w_len_full == 16'd0)                w_state_next = ST_CSUM;
                    else if ({1'b0, w_len_full} > LP_DEPTH) w_state_next = ST_ERROR;
                    else                                    w_state_next = ST_DATA_HI;
                end
            end
            ST_DATA_HI: if (w_xfer) w_state_next = ST_DATA_LO;
            ST_DATA_LO: begin
                if (w_xfer) w_state_next = (w_count_inc == r_len) ? ST_CSUM : ST_DATA_HI;
            end
            ST_CSUM: begin
                if (w_xfer) w_state_next = (i_rx_data == r_csum) ? ST_DONE : ST_ERROR;
            end
            ST_DONE:    w_state_next = ST_IDLE;
            ST_ERROR:   if (w_sync_start) w_state_next = ST_LEN_HI;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state: hold covers the whole frame plus DONE and ERROR
    always_comb begin
        w_rx_ready   = (r_state != ST_DONE);
        o_cpu_hold   = (r_state != ST_IDLE);
        o_load_done  = (r_state == ST_DONE);
        o_load_error = (r_state == ST_ERROR);
    end

    // Datapath: length, word count, address, high byte, running checksum and write port
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_len        <= 16'd0;
            r_count      <= 16'd0;
            r_addr       <= START_ADDR;
            r_hi         <= 8'd0;
            r_csum       <= 8'd0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
        end else begin
            r_imem_we <= 1'b0;
            if (w_sync_start) begin
                r_csum  <= 8'd0;
                r_count <= 16'd0;
                r_addr  <= START_ADDR;
            end else if (w_xfer) begin
                case (r_state)
                    ST_LEN_HI: begin
                        r_len[15:8] <= i_rx_data;
                        r_csum      <= r_csum ^ i_rx_data;
                    end
                    ST_LEN_LO: begin
                        r_len[7:0]  <= i_rx_data;
                        r_csum      <= r_csum ^ i_rx_data;
                    end
                    ST_DATA_HI: begin
                        r_hi        <= i_rx_data;
                        r_csum      <= r_csum ^ i_rx_data;
                    end
                    ST_DATA_LO: begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_addr;
                        r_imem_wdata <= {r_hi, i_rx_data};
                        r_addr       <= r_addr + 1'b1;
                        r_count      <= w_count_inc;
                        r_csum       <= r_csum ^ i_rx_data;
                    end
                    default: ;
                endcase
            end
            if (r_state == ST_DONE) begin
                r_addr <= START_ADDR;
            end
        end
    end

    assign o_rx_ready   = w_rx_ready;
    assign o_imem_we    = r_imem_we;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_wdata = r_imem_wdata;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: directed frames plus randomized frames with valid gaps.
// Expected writes and outcomes come from parsing each frame's byte list directly.
// Checks write strobe/address/data per byte, done/error/hold levels per frame, reset values.
module tb_instruction_loader;

    localparam logic [7:0] SYNC  = 8'hA5;
    localparam int         DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int done_cnt = 0;

    logic [7:0] fr[$];

    always #5 clk = ~clk;

    instruction_loader dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_rx_ready   (rx_ready),
        .o_imem_we    (imem_we),
        .o_imem_addr  (imem_addr),
        .o_imem_wdata (imem_wdata),
        .o_cpu_hold   (cpu_hold),
        .o_load_done  (load_done),
        .o_load_error (load_error)
    );

    // Count strobes and done pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_we)   we_cnt   <= we_cnt + 1;
            if (load_done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Present one byte, wait for it to transfer, then check the write port one edge later
    task automatic send_byte(input logic [7:0] b, input int gap, input bit exp_we,
                             input logic [15:0] exp_word, input logic [15:0] exp_addr);
        int n;
        @(negedge clk);
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        check("imem_we", 32'(imem_we), 32'(exp_we));
        if (exp_we) begin
            check("imem_addr", 32'(imem_addr), 32'(exp_addr));
            check("imem_wdata", 32'(imem_wdata), 32'(exp_word));
        end
    endtask

    // Reference parse of fr: first SYNC, length, words, xor checksum over length and data
    task automatic run_frame(input int gmode, input string tag);
        int s, len, we0, dn0, gap, nwr;
        bit bad_len, good, exp_we;
        logic [7:0]  csum;
        logic [15:0] word, addr;
        s = -1;
        for (int i = 0; i < fr.size(); i++) begin
            if (s < 0 && fr[i] == SYNC) s = i;
        end
        len     = {16'h0, fr[s+1], fr[s+2]};
        bad_len = (len > DEPTH);
        good    = 1'b0;
        if (!bad_len) begin
            csum = fr[s+1] ^ fr[s+2];
            for (int k = 0; k < 2*len; k++) csum = csum ^ fr[s+3+k];
            good = (fr[s+3+2*len] == csum);
        end
        we0 = we_cnt;
        dn0 = done_cnt;
        for (int j = 0; j < fr.size(); j++) begin
            exp_we = 1'b0;
            word   = 16'h0;
            addr   = 16'h0;
            if (!bad_len && j >= s+4 && j < s+3+2*len && ((j-s-4) % 2 == 0)) begin
                exp_we = 1'b1;
                word   = {fr[j-1], fr[j]};
                addr   = 16'((j-s-4)/2);
            end
            case (gmode)
                1:       gap = 1;
                2:       gap = int'($urandom_range(0, 2));
                default: gap = 0;
            endcase
            send_byte(fr[j], gap, exp_we, word, addr);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        nwr = bad_len ? 0 : len;
        check({tag, "_writes"}, 32'(we_cnt - we0), 32'(nwr));
        check({tag, "_done"}, 32'(done_cnt - dn0), 32'(good));
        check({tag, "_error"}, 32'(load_error), 32'(!good));
        check({tag, "_hold"}, 32'(cpu_hold), 32'(!good));
        check({tag, "_ready"}, 32'(rx_ready), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_done"}, 32'(load_done), 32'd0);
        check({tag, "_error"}, 32'(load_error), 32'd0);
        check({tag, "_ready"}, 32'(rx_ready), 32'd1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int we0, len, nn;
        logic [7:0] b, hi, lo, cs;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Good two-word image; checksum covers the length bytes, so it is 42
        fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_frame(0, "t1");
        // Same image with a wrong checksum byte
        fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        run_frame(0, "t2");
        // Length 257 exceeds depth; then an empty image recovers
        fr = '{8'hA5, 8'h01, 8'h01};
        run_frame(0, "t3_len");
        fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame(0, "t3_empty");
        // Leading noise, and sync-valued bytes inside the frame as data
        fr = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'h01};
        run_frame(0, "t4");

        // Largest accepted image: exactly DEPTH words
        fr.delete();
        fr.push_back(SYNC);
        fr.push_back(8'h01);
        fr.push_back(8'h00);
        cs = 8'h01;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom_range(0, 255));
            fr.push_back(b);
            fr.push_back(8'(i));
            cs = cs ^ b ^ 8'(i);
        end
        fr.push_back(cs);
        run_frame(2, "depth");

        // Reset in the middle of an image, right after the first high byte
        we0 = we_cnt;
        send_byte(8'hA5, 0, 1'b0, 16'h0, 16'h0);
        send_byte(8'h00, 0, 1'b0, 16'h0, 16'h0);
        send_byte(8'h02, 0, 1'b0, 16'h0, 16'h0);
        send_byte(8'h12, 0, 1'b0, 16'h0, 16'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_nowrite", 32'(we_cnt - we0), 32'd0);
        fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_frame(0, "t5_rerun");

        // Valid toggling every cycle
        fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_frame(1, "t6");

        // Random images: noise, short/oversized lengths, good/bad checksums, random gaps
        for (int f = 0; f < 40; f++) begin
            fr.delete();
            nn = int'($urandom_range(0, 3));
            for (int i = 0; i < nn; i++) begin
                do b = 8'($urandom_range(0, 255)); while (b == SYNC);
                fr.push_back(b);
            end
            fr.push_back(SYNC);
            if ($urandom_range(0, 9) == 0) begin
                len = DEPTH + 1 + int'($urandom_range(0, 60000));
                fr.push_back(8'(len >> 8));
                fr.push_back(8'(len));
            end else begin
                len = int'($urandom_range(0, 8));
                hi  = 8'(len >> 8);
                lo  = 8'(len);
                fr.push_back(hi);
                fr.push_back(lo);
                cs = hi ^ lo;
                for (int k = 0; k < 2*len; k++) begin
                    b = 8'($urandom_range(0, 255));
                    fr.push_back(b);
                    cs = cs ^ b;
                end
                if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
                fr.push_back(cs);
            end
            run_frame(int'($urandom_range(0, 2)), $sformatf("rnd%0d", f));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
